// File: rtl/f_pc_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_pc_ctrl_pkg : shared types, address defaults and fetch-legality helper |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package f_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_PEND = 2'd3
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_LIMIT = 32'h0000_6FFC;

  // Address error: misaligned word or outside the instruction memory window.
  function automatic logic pc_adel(input logic [31:0] pc,
                                   input logic [31:0] base,
                                   input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/f_pc_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_pc_ctrl_if : control inputs to and fetch outputs from the PC sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface f_pc_ctrl_if;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] F_PC;
  logic        F_valid;
  logic        F_adel;
  logic        pend_valid;

  modport master (
    output stall, redir_valid, redir_target, exc_req, eret_req, epc,
    input  F_PC, F_valid, F_adel, pend_valid
  );

  modport slave (
    input  stall, redir_valid, redir_target, exc_req, eret_req, epc,
    output F_PC, F_valid, F_adel, pend_valid
  );
endinterface
`default_nettype wire

// File: rtl/f_redir_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_redir_buf : one-entry redirect target buffer, clear beats load         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module f_redir_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);
  logic [31:0] target_q, target_d;
  logic        valid_q, valid_d;

  always_comb begin
    target_d = target_q;
    valid_d  = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      target_d = din;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      valid_q  <= valid_d;
    end
  end

  assign dout  = target_q;
  assign valid = valid_q;
endmodule
`default_nettype wire

// File: rtl/f_pc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_pc_ctrl : F-stage PC sequencer (boot, sequential, redirect, stall,     |
// |             buffered redirect, optional exception entry EXC_REDIRECT_EN) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module f_pc_ctrl
  import f_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  f_pc_ctrl_if.slave  pc_if
);
  pc_state_e   state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        f_valid_q, f_valid_d;
  logic        f_adel_q, f_adel_d;
  logic        buf_load, buf_clear;
  logic [31:0] buf_dout;
  logic        buf_valid;
  logic        exc_take, eret_take;
  logic [31:0] eret_pc;

`ifdef EXC_REDIRECT_EN
  assign exc_take  = pc_if.exc_req;
  assign eret_take = pc_if.eret_req;
  assign eret_pc   = pc_if.epc;
`else
  logic unused_exc;
  assign unused_exc = ^{pc_if.exc_req, pc_if.eret_req, pc_if.epc};
  assign exc_take   = 1'b0;
  assign eret_take  = 1'b0;
  assign eret_pc    = 32'h0;
`endif

  always_comb begin
    state_d   = state_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (state_q == ST_BOOT) begin
      f_valid_d = 1'b1;
      state_d   = ST_RUN;
    end else if (exc_take) begin
      f_pc_d    = EXC_PC;
      buf_clear = 1'b1;
      state_d   = ST_RUN;
    end else if (pc_if.stall) begin
      // A redirect seen while stalled is parked so it survives the stall.
      if (pc_if.redir_valid) begin
        buf_load = 1'b1;
        state_d  = ST_PEND;
      end else if (state_q == ST_RUN) begin
        state_d = ST_HOLD;
      end
    end else begin
      buf_clear = 1'b1;
      state_d   = ST_RUN;
      if (eret_take) begin
        f_pc_d = eret_pc;
      end else if (pc_if.redir_valid) begin
        f_pc_d = pc_if.redir_target;
      end else if (state_q == ST_PEND) begin
        f_pc_d = buf_dout;
      end else begin
        f_pc_d = f_pc_q + 32'd4;
      end
    end
    f_adel_d = pc_adel(f_pc_d, IM_BASE, IM_LIMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      f_pc_q    <= RESET_PC;
      f_valid_q <= 1'b0;
      f_adel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      f_adel_q  <= f_adel_d;
    end
  end

  f_redir_buf u_redir_buf (
    .clk   (clk),
    .rst_n (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (pc_if.redir_target),
    .dout  (buf_dout),
    .valid (buf_valid)
  );

  assign pc_if.F_PC       = f_pc_q;
  assign pc_if.F_valid    = f_valid_q;
  assign pc_if.F_adel     = f_adel_q;
  assign pc_if.pend_valid = buf_valid;
endmodule
`default_nettype wire
